tone_arbiter: RTL



---
 rtl/tone_pkg.sv | 37 +++
 rtl/milli_prescaler.sv | 36 +++
 rtl/tone_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/tone_pkg.sv
// Shared types and constants for the tone arbiter and its millisecond prescaler.
// Note constants are in Hz and match the default frequency width.
package tone_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TONE = 2'd1,
    ST_GAP  = 2'd2
  } tone_state_t;

  localparam int DEF_NUM_REQ   = 3;
  localparam int DEF_FREQ_BITS = 10;
  localparam int DEF_DUR_BITS  = 10;
  localparam int DEF_GAP_BITS  = 8;
  localparam int TPM_BITS      = 6;

  localparam logic [DEF_FREQ_BITS-1:0] NOTE_REST = 10'd0;
  localparam logic [DEF_FREQ_BITS-1:0] NOTE_G3   = 10'd196;
  localparam logic [DEF_FREQ_BITS-1:0] NOTE_A3   = 10'd220;
  localparam logic [DEF_FREQ_BITS-1:0] NOTE_C4   = 10'd262;
  localparam logic [DEF_FREQ_BITS-1:0] NOTE_D4   = 10'd294;
  localparam logic [DEF_FREQ_BITS-1:0] NOTE_E4   = 10'd330;
  localparam logic [DEF_FREQ_BITS-1:0] NOTE_F4   = 10'd349;
  localparam logic [DEF_FREQ_BITS-1:0] NOTE_G4   = 10'd392;
  localparam logic [DEF_FREQ_BITS-1:0] NOTE_A4   = 10'd440;
  localparam logic [DEF_FREQ_BITS-1:0] NOTE_B4   = 10'd494;
  localparam logic [DEF_FREQ_BITS-1:0] NOTE_C5   = 10'd523;
  localparam logic [DEF_FREQ_BITS-1:0] NOTE_D5   = 10'd587;
  localparam logic [DEF_FREQ_BITS-1:0] NOTE_E5   = 10'd659;
  localparam logic [DEF_FREQ_BITS-1:0] NOTE_G5   = 10'd784;

  // A programmed period of 0 behaves like 1 so the prescaler always advances.
  function automatic logic [TPM_BITS-1:0] eff_tpm(input logic [TPM_BITS-1:0] tpm);
    return (tpm < TPM_BITS'(2)) ? TPM_BITS'(1) : tpm;
  endfunction

endpackage

// File: rtl/milli_prescaler.sv
// Divides the system clock down to a one-cycle millisecond strobe.
// The period is latched on clear and on each wrap, so a new rate applies from the next wrap.
module milli_prescaler
  import tone_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                ena,
  input  logic [TPM_BITS-1:0] ticks_per_milli,
  output logic                milli
);

  logic [TPM_BITS-1:0] cnt;
  logic [TPM_BITS-1:0] period;

  assign milli = ena && (cnt == (period - TPM_BITS'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      period <= TPM_BITS'(1);
    end else if (clear) begin
      cnt    <= '0;
      period <= eff_tpm(ticks_per_milli);
    end else if (ena) begin
      if (milli) begin
        cnt    <= '0;
        period <= eff_tpm(ticks_per_milli);
      end else begin
        cnt <= cnt + TPM_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/tone_arbiter.sv
// Fixed-priority arbiter sharing one tone generator among NUM_REQ note requesters.
// Define TONE_ARB_PREEMPT_EN to let a higher-priority request abort the note in progress.
module tone_arbiter
  import tone_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int FREQ_BITS = DEF_FREQ_BITS,
  parameter int DUR_BITS  = DEF_DUR_BITS,
  parameter int GAP_BITS  = DEF_GAP_BITS,
  parameter int ID_BITS   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [TPM_BITS-1:0]           ticks_per_milli,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*FREQ_BITS-1:0]  req_freq,
  input  logic [NUM_REQ*DUR_BITS-1:0]   req_dur,
  input  logic [NUM_REQ*GAP_BITS-1:0]   req_gap,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            done,
  output logic [NUM_REQ-1:0]            abort,
  output logic [FREQ_BITS-1:0]          freq,
  output logic                          busy,
  output logic [ID_BITS-1:0]            owner
);

  localparam int CNT_BITS = (DUR_BITS > GAP_BITS) ? DUR_BITS : GAP_BITS;

  tone_state_t         state, state_n;
  logic [FREQ_BITS-1:0] freq_n;
  logic [ID_BITS-1:0]   owner_n;
  logic [NUM_REQ-1:0]   done_n;
  logic [CNT_BITS-1:0]  ms_cnt, ms_n;
  logic [DUR_BITS-1:0]  cap_dur, dur_n;
  logic [GAP_BITS-1:0]  cap_gap, gap_n;

  logic                 any_valid;
  logic [ID_BITS-1:0]   pick;
  logic [FREQ_BITS-1:0] sel_freq;
  logic [DUR_BITS-1:0]  sel_dur;
  logic [GAP_BITS-1:0]  sel_gap;
  logic                 load;
  logic                 presc_clear;
  logic                 milli;
  logic                 dur_last;
  logic                 gap_last;

  // Lowest index wins: scan downwards so the last hit is the highest priority.
  always_comb begin
    any_valid = 1'b0;
    pick      = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        any_valid = 1'b1;
        pick      = ID_BITS'(i);
      end
    end
  end

  assign sel_freq = req_freq[pick*FREQ_BITS +: FREQ_BITS];
  assign sel_dur  = req_dur[pick*DUR_BITS +: DUR_BITS];
  assign sel_gap  = req_gap[pick*GAP_BITS +: GAP_BITS];

  assign dur_last = (ms_cnt == (CNT_BITS'(cap_dur) - CNT_BITS'(1)));
  assign gap_last = (ms_cnt == (CNT_BITS'(cap_gap) - CNT_BITS'(1)));
  assign busy     = (state != ST_IDLE);

  milli_prescaler u_presc (
    .clk             (clk),
    .rst_n           (rst_n),
    .clear           (presc_clear),
    .ena             (busy),
    .ticks_per_milli (ticks_per_milli),
    .milli           (milli)
  );

  always_comb begin
    state_n     = state;
    freq_n      = freq;
    owner_n     = owner;
    done_n      = '0;
    ms_n        = ms_cnt;
    dur_n       = cap_dur;
    gap_n       = cap_gap;
    load        = 1'b0;
    presc_clear = 1'b0;
    req_ready   = '0;
    abort       = '0;

    case (state)
      ST_IDLE: begin
        presc_clear = 1'b1;
        ms_n        = '0;
        freq_n      = '0;
        load        = any_valid;
      end
      ST_TONE: begin
        if (milli) begin
          if (dur_last) begin
            ms_n   = '0;
            freq_n = '0;
            if (cap_gap == '0) begin
              state_n       = ST_IDLE;
              done_n[owner] = 1'b1;
            end else begin
              state_n = ST_GAP;
            end
          end else begin
            ms_n = ms_cnt + CNT_BITS'(1);
          end
        end
      end
      ST_GAP: begin
        freq_n = '0;
        if (milli) begin
          if (gap_last) begin
            ms_n          = '0;
            state_n       = ST_IDLE;
            done_n[owner] = 1'b1;
          end else begin
            ms_n = ms_cnt + CNT_BITS'(1);
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        freq_n  = '0;
      end
    endcase

`ifdef TONE_ARB_PREEMPT_EN
    // A strictly higher-priority request takes over without an IDLE cycle.
    if (busy && any_valid && (pick < owner)) begin
      abort[owner] = 1'b1;
      load         = 1'b1;
    end
`endif

    // Accepting a note overrides whatever the running note would have done.
    if (load) begin
      req_ready[pick] = 1'b1;
      owner_n         = pick;
      dur_n           = sel_dur;
      gap_n           = sel_gap;
      ms_n            = '0;
      presc_clear     = 1'b1;
      done_n          = '0;
      if (sel_dur != '0) begin
        state_n = ST_TONE;
        freq_n  = sel_freq;
      end else if (sel_gap != '0) begin
        state_n = ST_GAP;
        freq_n  = '0;
      end else begin
        state_n      = ST_IDLE;
        freq_n       = '0;
        done_n[pick] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      freq    <= '0;
      owner   <= '0;
      done    <= '0;
      ms_cnt  <= '0;
      cap_dur <= '0;
      cap_gap <= '0;
    end else begin
      state   <= state_n;
      freq    <= freq_n;
      owner   <= owner_n;
      done    <= done_n;
      ms_cnt  <= ms_n;
      cap_dur <= dur_n;
      cap_gap <= gap_n;
    end
  end

endmodule
